// File: rtl/bus_transceiver_bank.sv
`default_nettype none
// ============================================================================
// Module      : bus_transceiver_bank
// Description : Registered fixed-priority fan-in of CHANNELS bus drivers with
//               active-low enables. Falls back to the live bus value when no
//               channel drives, and tracks multi-driver (contention) cycles
//               with a pulse, a sticky flag and a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_transceiver_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int SRC_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in,
    input  logic [CHANNELS-1:0]       oe,
    input  logic [WIDTH-1:0]          bus,
    input  logic                      clr_err,
    output logic [WIDTH-1:0]          out,
    output logic                      driving,
    output logic [SRC_W-1:0]          src,
    output logic                      contention,
    output logic                      err_sticky,
    output logic [CNT_W-1:0]          err_count
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CHANNELS-1:0] w_en;
    logic                w_any;
    logic                w_multi;
    logic [SRC_W-1:0]    w_sel_idx;
    logic [WIDTH-1:0]    w_sel_data;

    logic [WIDTH-1:0]    r_out;
    logic                r_driving;
    logic [SRC_W-1:0]    r_src;
    logic                r_contention;
    logic                r_err_sticky;
    logic [CNT_W-1:0]    r_err_count;

    // Enabled set, lowest-index winner and multi-driver detection.
    always_comb begin
        w_en       = ~oe;
        w_any      = |w_en;
        // Clearing the lowest set bit leaves something only if two or more are set.
        w_multi    = |(w_en & (w_en - CHANNELS'(1)));
        w_sel_idx  = '0;
        w_sel_data = '0;
        // Scan downward so the lowest enabled index is the last to write.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            if (w_en[k]) begin
                w_sel_idx  = SRC_W'(k);
                w_sel_data = in[k*WIDTH +: WIDTH];
            end
        end
    end

    // Registered data path: winning channel, or the bus itself when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out     <= '0;
            r_driving <= 1'b0;
            r_src     <= '0;
        end else if (w_any) begin
            r_out     <= w_sel_data;
            r_driving <= 1'b1;
            r_src     <= w_sel_idx;
        end else begin
            r_out     <= bus;
            r_driving <= 1'b0;
        end
    end

    // Contention bookkeeping; a contention cycle overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_contention <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_contention <= w_multi;
            if (w_multi) begin
                r_err_sticky <= 1'b1;
                if (clr_err) begin
                    r_err_count <= CNT_W'(1);
                end else if (r_err_count != c_CNT_MAX) begin
                    r_err_count <= r_err_count + CNT_W'(1);
                end
            end else if (clr_err) begin
                r_err_sticky <= 1'b0;
                r_err_count  <= '0;
            end
        end
    end

    assign out        = r_out;
    assign driving    = r_driving;
    assign src        = r_src;
    assign contention = r_contention;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_bus_transceiver_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_transceiver_bank
// Description : Scoreboard bench for bus_transceiver_bank (WIDTH=8,
//               CHANNELS=4, CNT_W=2). Stimulus pushes expected outputs into a
//               queue; a monitor pops and compares one entry per clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_transceiver_bank;

    localparam int c_W     = 8;
    localparam int c_CH    = 4;
    localparam int c_CNT_W = 2;
    localparam int c_SRC_W = 2;
    localparam int c_CMAX  = (1 << c_CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [c_CH*c_W-1:0]   in_v;
    logic [c_CH-1:0]       oe;
    logic [c_W-1:0]        bus;
    logic                  clr_err;
    logic [c_W-1:0]        out;
    logic                  driving;
    logic [c_SRC_W-1:0]    src;
    logic                  contention;
    logic                  err_sticky;
    logic [c_CNT_W-1:0]    err_count;

    typedef struct {
        int out;
        int drv;
        int src;
        int con;
        int st;
        int cnt;
    } exp_t;

    exp_t q[$];
    exp_t m;
    int   tests  = 0;
    int   failed = 0;

    bus_transceiver_bank #(
        .WIDTH   (c_W),
        .CHANNELS(c_CH),
        .CNT_W   (c_CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (in_v),
        .oe        (oe),
        .bus       (bus),
        .clr_err   (clr_err),
        .out       (out),
        .driving   (driving),
        .src       (src),
        .contention(contention),
        .err_sticky(err_sticky),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input int exp_v);
        tests++;
        if (act !== 32'(exp_v)) begin
            failed++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: every output cycle that has an expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out",        32'(out),        e.out);
                chk("driving",    32'(driving),    e.drv);
                chk("src",        32'(src),        e.src);
                chk("contention", 32'(contention), e.con);
                chk("err_sticky", 32'(err_sticky), e.st);
                chk("err_count",  32'(err_count),  e.cnt);
            end
        end
    end

    // Apply one cycle of inputs and record what the outputs must be after it.
    task automatic step(input logic r, input logic [c_CH*c_W-1:0] d,
                        input logic [c_CH-1:0] o, input logic [c_W-1:0] b,
                        input logic c);
        int en[$];
        @(negedge clk);
        reset = r; in_v = d; oe = o; bus = b; clr_err = c;
        if (r) begin
            m = '{0, 0, 0, 0, 0, 0};
        end else begin
            for (int k = 0; k < c_CH; k++)
                if (o[k] == 1'b0) en.push_back(k);
            if (en.size() > 0) begin
                m.out = int'(d[en[0]*c_W +: c_W]);
                m.drv = 1;
                m.src = en[0];
            end else begin
                m.out = int'(b);
                m.drv = 0;
            end
            m.con = (en.size() >= 2) ? 1 : 0;
            if (en.size() >= 2) begin
                m.st  = 1;
                m.cnt = c ? 1 : ((m.cnt + 1 > c_CMAX) ? c_CMAX : m.cnt + 1);
            end else if (c) begin
                m.st  = 0;
                m.cnt = 0;
            end
        end
        q.push_back(m);
        @(posedge clk);
    endtask

    function automatic logic [c_CH*c_W-1:0] pack4(input logic [7:0] c3, input logic [7:0] c2,
                                                   input logic [7:0] c1, input logic [7:0] c0);
        return {c3, c2, c1, c0};
    endfunction

    initial begin
        int guard;
        m = '{0, 0, 0, 0, 0, 0};
        reset = 1'b1; in_v = '0; oe = '1; bus = '0; clr_err = 1'b0;

        // Reset, including with all channels enabled and clear requested.
        step(1, pack4(8'h12, 8'h34, 8'h56, 8'h78), 4'hF, 8'h55, 0);
        step(1, pack4(8'h12, 8'h34, 8'h56, 8'h78), 4'h0, 8'hAA, 1);

        // Single driver on channel 2, then idle follow with src held.
        step(0, pack4(8'h00, 8'hA5, 8'h00, 8'h00), 4'b1011, 8'h00, 0);
        step(0, pack4(8'hDE, 8'hAD, 8'hBE, 8'hEF), 4'b1111, 8'h3C, 0);

        // Priority with contention, then clear while idle.
        step(0, pack4(8'h33, 8'h00, 8'h11, 8'h00), 4'b0101, 8'h00, 0);
        step(0, pack4(8'h33, 8'h00, 8'h11, 8'h00), 4'b1111, 8'h99, 1);

        // Five contention cycles: counter saturates at 3.
        for (int i = 0; i < 5; i++)
            step(0, pack4(8'h44, 8'h33, 8'h22, 8'h11), 4'b0000, 8'h00, 0);

        // Clear colliding with contention, then a clean clear.
        step(0, pack4(8'h44, 8'h33, 8'h22, 8'h11), 4'b1100, 8'h00, 1);
        step(0, pack4(8'h44, 8'h33, 8'h22, 8'h11), 4'b1110, 8'h00, 1);

        // Reset during contention, then recovery on channel 0.
        step(0, pack4(8'h33, 8'h00, 8'h11, 8'h00), 4'b0101, 8'h00, 0);
        step(1, pack4(8'h33, 8'h00, 8'h11, 8'h00), 4'b0101, 8'h00, 0);
        step(0, pack4(8'h00, 8'h00, 8'h00, 8'h7F), 4'b1110, 8'h00, 0);

        // Randomized traffic, enables biased toward few drivers.
        for (int i = 0; i < 400; i++) begin
            logic [c_CH-1:0] o;
            o = 4'($urandom) | 4'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom), o, 8'($urandom),
                 ($urandom_range(0, 7) == 0));
        end

        @(negedge clk);
        guard = 0;
        while (q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (q.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain actual=%0d expected=0 entries left", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
